// File: rtl/reg_rename_file.sv
// Architectural register file with per-register ROB rename tags.
// Optional same-cycle commit bypass on the read ports: define REGFILE_BYPASS_EN.
module reg_rename_file #(
    parameter int XLEN = 32,
    parameter int NREG = 32,
    parameter int TAGW = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            rdy,
    input  logic            flush,
    input  logic            ren_valid,
    input  logic [4:0]      ren_rd,
    input  logic [TAGW-1:0] ren_pos,
    input  logic            cm_valid,
    input  logic [4:0]      cm_dest,
    input  logic [TAGW-1:0] cm_pos,
    input  logic [XLEN-1:0] cm_value,
    input  logic [4:0]      rs1_addr,
    input  logic [4:0]      rs2_addr,
    output logic            rs1_busy,
    output logic            rs2_busy,
    output logic [TAGW-1:0] rs1_tag,
    output logic [TAGW-1:0] rs2_tag,
    output logic [XLEN-1:0] rs1_val,
    output logic [XLEN-1:0] rs2_val
);

    typedef struct packed {
        logic            busy;
        logic [TAGW-1:0] tag;
        logic [XLEN-1:0] val;
    } rd_t;

    logic [XLEN-1:0] regs_q [NREG];
    logic [XLEN-1:0] regs_d [NREG];
    logic            busy_q [NREG];
    logic            busy_d [NREG];
    logic [TAGW-1:0] tag_q  [NREG];
    logic [TAGW-1:0] tag_d  [NREG];

    rd_t rd1, rd2;

    always_comb begin
        regs_d = regs_q;
        busy_d = busy_q;
        tag_d  = tag_q;
        if (rdy) begin
            if (flush) begin
                for (int i = 0; i < NREG; i++) begin
                    busy_d[i] = 1'b0;
                    tag_d[i]  = '0;
                end
            end else begin
                if (cm_valid && cm_dest != 5'd0) begin
                    regs_d[cm_dest] = cm_value;
                    // A mismatching tag means a younger writer still owns the register.
                    if (busy_q[cm_dest] && tag_q[cm_dest] == cm_pos) begin
                        busy_d[cm_dest] = 1'b0;
                        tag_d[cm_dest]  = '0;
                    end
                end
                // Rename is applied last so it wins over a same-register commit.
                if (ren_valid && ren_rd != 5'd0) begin
                    busy_d[ren_rd] = 1'b1;
                    tag_d[ren_rd]  = ren_pos;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= '0;
                busy_q[i] <= 1'b0;
                tag_q[i]  <= '0;
            end
        end else begin
            regs_q <= regs_d;
            busy_q <= busy_d;
            tag_q  <= tag_d;
        end
    end

    function automatic rd_t read_port(input logic [4:0] a);
        rd_t r;
        r = '0;
        if (a != 5'd0) begin
            if (busy_q[a]) begin
                r.busy = 1'b1;
                r.tag  = tag_q[a];
            end else begin
                r.val = regs_q[a];
            end
`ifdef REGFILE_BYPASS_EN
            if (!flush && cm_valid && cm_dest == a && busy_q[a] && tag_q[a] == cm_pos) begin
                r.busy = 1'b0;
                r.tag  = '0;
                r.val  = cm_value;
            end
`endif
        end
        return r;
    endfunction

    always_comb begin
        rd1 = read_port(rs1_addr);
        rd2 = read_port(rs2_addr);
    end

    assign rs1_busy = rd1.busy;
    assign rs1_tag  = rd1.tag;
    assign rs1_val  = rd1.val;
    assign rs2_busy = rd2.busy;
    assign rs2_tag  = rd2.tag;
    assign rs2_val  = rd2.val;

endmodule

// File: tb/tb_reg_rename_file.sv
// Self-checking bench for reg_rename_file: directed vectors, array-based reference
// model compared every cycle, plus hand-computed literal expectations.
module tb_reg_rename_file;

    localparam int XLEN = 32;
    localparam int NREG = 32;
    localparam int TAGW = 4;
`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            rdy = 1'b1;
    logic            flush = 1'b0;
    logic            ren_valid = 1'b0;
    logic [4:0]      ren_rd = '0;
    logic [TAGW-1:0] ren_pos = '0;
    logic            cm_valid = 1'b0;
    logic [4:0]      cm_dest = '0;
    logic [TAGW-1:0] cm_pos = '0;
    logic [XLEN-1:0] cm_value = '0;
    logic [4:0]      rs1_addr = '0;
    logic [4:0]      rs2_addr = '0;
    logic            rs1_busy, rs2_busy;
    logic [TAGW-1:0] rs1_tag, rs2_tag;
    logic [XLEN-1:0] rs1_val, rs2_val;

    int n_checks = 0;
    int n_errors = 0;
    bit chk_en = 1'b0;

    reg_rename_file #(.XLEN(XLEN), .NREG(NREG), .TAGW(TAGW)) dut (
        .clk(clk), .rst(rst), .rdy(rdy), .flush(flush),
        .ren_valid(ren_valid), .ren_rd(ren_rd), .ren_pos(ren_pos),
        .cm_valid(cm_valid), .cm_dest(cm_dest), .cm_pos(cm_pos), .cm_value(cm_value),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
        .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
        .rs1_tag(rs1_tag), .rs2_tag(rs2_tag),
        .rs1_val(rs1_val), .rs2_val(rs2_val)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: what each architectural register holds and who owns it.
    logic [XLEN-1:0] m_regs [NREG];
    bit              m_busy [NREG];
    logic [TAGW-1:0] m_tag  [NREG];

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                m_regs[i] = '0;
                m_busy[i] = 1'b0;
                m_tag[i]  = '0;
            end
        end else if (rdy) begin
            if (flush) begin
                for (int i = 0; i < NREG; i++) begin
                    m_busy[i] = 1'b0;
                    m_tag[i]  = '0;
                end
            end else begin
                if (cm_valid && cm_dest != 0) begin
                    m_regs[cm_dest] = cm_value;
                    if (m_busy[cm_dest] && m_tag[cm_dest] == cm_pos) begin
                        m_busy[cm_dest] = 1'b0;
                        m_tag[cm_dest]  = '0;
                    end
                end
                if (ren_valid && ren_rd != 0) begin
                    m_busy[ren_rd] = 1'b1;
                    m_tag[ren_rd]  = ren_pos;
                end
            end
        end
    end

    // Expected {busy, tag, val} seen by a read port this cycle.
    function automatic logic [XLEN+TAGW:0] exp_read(input logic [4:0] a);
        logic            b;
        logic [TAGW-1:0] t;
        logic [XLEN-1:0] v;
        b = 1'b0; t = '0; v = '0;
        if (a != 0) begin
            if (BYP && !flush && cm_valid && cm_dest == a && m_busy[a] && m_tag[a] == cm_pos) begin
                v = cm_value;
            end else if (m_busy[a]) begin
                b = 1'b1;
                t = m_tag[a];
            end else begin
                v = m_regs[a];
            end
        end
        return {b, t, v};
    endfunction

    always @(negedge clk) begin
        logic [XLEN+TAGW:0] e1, e2;
        #2;
        if (chk_en) begin
            e1 = exp_read(rs1_addr);
            e2 = exp_read(rs2_addr);
            check("model rs1_busy", {31'd0, rs1_busy}, {31'd0, e1[XLEN+TAGW]});
            check("model rs1_tag", {28'd0, rs1_tag}, {28'd0, e1[XLEN+TAGW-1:XLEN]});
            check("model rs1_val", rs1_val, e1[XLEN-1:0]);
            check("model rs2_busy", {31'd0, rs2_busy}, {31'd0, e2[XLEN+TAGW]});
            check("model rs2_tag", {28'd0, rs2_tag}, {28'd0, e2[XLEN+TAGW-1:XLEN]});
            check("model rs2_val", rs2_val, e2[XLEN-1:0]);
        end
    end

    // Start a cycle: inputs return to idle right after the falling edge.
    task automatic next_cycle();
        @(negedge clk);
        rdy = 1'b1; flush = 1'b0; ren_valid = 1'b0; cm_valid = 1'b0;
    endtask

    task automatic ren(input logic [4:0] rd, input logic [TAGW-1:0] pos);
        ren_valid = 1'b1; ren_rd = rd; ren_pos = pos;
    endtask

    task automatic cm(input logic [4:0] rd, input logic [TAGW-1:0] pos, input logic [XLEN-1:0] v);
        cm_valid = 1'b1; cm_dest = rd; cm_pos = pos; cm_value = v;
    endtask

    task automatic lit1(input string name, input logic b, input logic [TAGW-1:0] t, input logic [XLEN-1:0] v);
        #3;
        check({name, " busy"}, {31'd0, rs1_busy}, {31'd0, b});
        check({name, " tag"}, {28'd0, rs1_tag}, {28'd0, t});
        check({name, " val"}, rs1_val, v);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk_en = 1'b1;

        // Reset state, then commit to a non-busy register.
        rs1_addr = 5'd5; rs2_addr = 5'd0; cm(5'd5, 4'd3, 32'hDEADBEEF);
        lit1("reset x5", 1'b0, 4'd0, 32'd0);
        next_cycle(); ren(5'd7, 4'd4);
        lit1("commit x5", 1'b0, 4'd0, 32'hDEADBEEF);
        next_cycle(); rs1_addr = 5'd7; cm(5'd7, 4'd4, 32'h11);
        lit1("renamed x7", ~BYP, BYP ? 4'd0 : 4'd4, BYP ? 32'h11 : 32'd0);
        next_cycle(); ren(5'd7, 4'd4);
        lit1("x7 committed", 1'b0, 4'd0, 32'h11);

        // Younger writer keeps the register busy.
        next_cycle(); ren(5'd7, 4'd9);
        lit1("x7 tag4", 1'b1, 4'd4, 32'd0);
        next_cycle(); cm(5'd7, 4'd4, 32'h22);
        lit1("x7 tag9", 1'b1, 4'd9, 32'd0);
        next_cycle(); ren(5'd3, 4'd2);
        lit1("x7 still busy", 1'b1, 4'd9, 32'd0);
        check("model x7 regs", m_regs[7], 32'h22);

        // Same-cycle commit and rename of x3.
        next_cycle(); rs1_addr = 5'd3; rs2_addr = 5'd7; cm(5'd3, 4'd2, 32'h33); ren(5'd3, 4'd6);
        lit1("x3 same cycle", ~BYP, BYP ? 4'd0 : 4'd2, BYP ? 32'h33 : 32'd0);
        next_cycle(); cm(5'd1, 4'd0, 32'hA5A5);
        lit1("x3 renamed", 1'b1, 4'd6, 32'd0);

        // Rename x1..x3 then flush with a wrong-path commit on x1.
        next_cycle(); rs1_addr = 5'd1; ren(5'd1, 4'd1);
        lit1("x1 committed", 1'b0, 4'd0, 32'hA5A5);
        next_cycle(); rs2_addr = 5'd2; ren(5'd2, 4'd2);
        next_cycle(); rs2_addr = 5'd3; ren(5'd3, 4'd3);
        lit1("x1 busy", 1'b1, 4'd1, 32'd0);
        next_cycle(); flush = 1'b1; cm(5'd1, 4'd1, 32'h0BAD);
        lit1("x1 during flush", 1'b1, 4'd1, 32'd0);
        next_cycle();
        lit1("x1 after flush", 1'b0, 4'd0, 32'hA5A5);
        check("x3 after flush", rs2_val, 32'h33);
        check("x3 busy after flush", {31'd0, rs2_busy}, 32'd0);

        // x0 writes dropped; rdy low holds state, including a flush.
        next_cycle(); rs1_addr = 5'd0; rs2_addr = 5'd4; ren(5'd0, 4'd5); cm(5'd0, 4'd5, 32'hFFFF);
        next_cycle(); rdy = 1'b0; ren(5'd4, 4'd7);
        lit1("x0 read", 1'b0, 4'd0, 32'd0);
        check("model x0 regs", m_regs[0], 32'd0);
        next_cycle(); rs1_addr = 5'd4; ren(5'd5, 4'd8);
        lit1("x4 held", 1'b0, 4'd0, 32'd0);
        next_cycle(); rdy = 1'b0; flush = 1'b1; rs1_addr = 5'd5;
        lit1("x5 flush rdy low", 1'b1, 4'd8, 32'd0);
        next_cycle();
        lit1("x5 after held flush", 1'b1, 4'd8, 32'd0);
        next_cycle(); rs2_addr = 5'd7; cm(5'd5, 4'd8, 32'h55);
        next_cycle();
        lit1("x5 final", 1'b0, 4'd0, 32'h55);
        next_cycle();
        chk_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/reg_rename_file.md
# reg_rename_file

Architectural register file with per-register rename tags, sitting between the decoder and the reorder buffer. Each cycle it:
- renames the decoded instruction's destination to its new ROB slot;
- writes the value committed by the ROB;
- returns, for both source operands, either a ready value or the ROB slot that will produce it.

A mispredict flush discards all outstanding renames.

## Interface
Parameters:
- XLEN, 32, data width
- NREG, 32, architectural register count (x0 hardwired zero)
- TAGW, 4, ROB position width (16-entry ROB)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- rdy  in  1  global enable; low = hold all state
- flush  in  1  ROB jump_wrong; discard all renames
- ren_valid  in  1  decoder issues an instruction with rd != 0 (ROB update_ROB_valid)
- ren_rd  in  5  destination register being renamed
- ren_pos  in  TAGW  ROB slot allocated to it
- cm_valid  in  1  ROB commits a register write
- cm_dest  in  5  committed destination
- cm_pos  in  TAGW  ROB slot being committed
- cm_value  in  XLEN  committed value
- rs1_addr, rs2_addr  in  5  source register indices from decoder
- rs1_busy, rs2_busy  out  1  operand awaits ROB slot
- rs1_tag, rs2_tag  out  TAGW  producing ROB slot, 0 when not busy
- rs1_val, rs2_val  out  XLEN  architectural value, 0 when busy

## Operation
- State:
  - regs[NREG] of XLEN
  - busy[NREG]
  - tag[NREG] of TAGW
- Reads are combinational from current state.
  - x0 always reads val=0, busy=0, tag=0.
- Update on posedge clk, evaluated in this priority order:
  1. rst: regs, busy, tag all 0.
  2. !rdy: hold everything.
  3. flush: busy and tag all cleared to 0. regs unchanged. cm_* and ren_* of that cycle ignored; the commit slot is wrong-path.
  4. Otherwise, commit and rename as below.
- Commit (cm_valid, cm_dest != 0):
  - regs[cm_dest] <= cm_value.
  - If busy[cm_dest] and tag[cm_dest] == cm_pos: busy <= 0, tag <= 0.
  - A mismatching tag leaves busy set, because a younger writer is pending.
- Rename (ren_valid, ren_rd != 0): busy[ren_rd] <= 1, tag[ren_rd] <= ren_pos.
- Same register committed and renamed in one cycle: rename wins on busy/tag; regs still takes cm_value.
- Source reads see pre-rename state. For add x1,x1,x2, rs1 reports the previous producer of x1, not ren_pos.
- Writes to x0 are dropped on both paths.

## Timing
- Read latency 0 (combinational). Write latency 1: a rename or commit becomes visible to reads the cycle after.
- Reset value of every output: val=0, busy=0, tag=0 for any address.
- First clean cycle after flush: every register reads busy=0 with its last committed value.
- Flush during rdy low has no effect until rdy is high.

## Configuration
- REGFILE_BYPASS_EN defined:
  - In the same cycle, cm_valid with cm_dest == rsN_addr != 0, busy and tag == cm_pos makes read port N report busy=0, tag=0, val=cm_value.
  - Suppressed when flush is high.
  - Adds a comparator and mux per port. Removes one cycle of RS wakeup latency.
- Undefined: no bypass. The read reports busy with the tag; the value is visible the next cycle.

## Test plan
- Reset, then read x5 -> busy=0, tag=0, val=0. Commit x5=0xDEADBEEF pos 3 (not busy) -> next cycle val=0xDEADBEEF, busy=0.
- Rename x7 pos 4; next cycle read x7 -> busy=1, tag=4, val=0. Commit x7 pos 4 value 0x11 -> following cycle busy=0, val=0x11.
- Rename x7 pos 4, then x7 pos 9. Commit x7 pos 4 value 0x22 -> regs=0x22, still busy=1, tag=9.
- Same cycle: commit x3 pos 2 (busy, tag 2), rename x3 pos 6, read rs1=x3.
  - Read shows tag 2, busy=1 (bypass off) or val=cm_value, busy=0 (bypass on).
  - Next cycle busy=1, tag=6.
- Rename x1,x2,x3 (pos 1–3), then flush together with cm_valid for x1 -> all busy=0, x1 value unchanged from before flush.
- Rename and commit targeting x0, and rdy=0 with ren_valid on x4 -> x0 reads 0/not busy; x4 unchanged.
